// File: rtl/led_pwm_ctrl.sv
// Per-channel LED PWM (OFF/STEADY/BLINK/BREATHE). A config slot is applied only at a PWM period wrap, and cfg_ready stays low while it waits.
// pwm_out is registered 1 cycle after pwm_cnt. The breathing generator is built only with LED_PWM_CTRL_BREATHE_EN defined.
module led_pwm_ctrl #(
  parameter int CHANNELS    = 3,
  parameter int PWM_BITS    = 8,
  parameter int TICK_DIV    = 48000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                tick_out
);
  localparam int PSW = $clog2(TICK_DIV);
  localparam int BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STEADY  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic [PSW-1:0]      presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_wrap;
  logic                rdy_q;
  logic                pending;
  logic                cfg_xfer;
  logic [2:0]          pend_chan;
  mode_e               pend_mode;
  logic [PWM_BITS-1:0] pend_duty;
  mode_e               mode_q   [CHANNELS];
  logic [PWM_BITS-1:0] duty_q   [CHANNELS];
  logic [PWM_BITS-1:0] eff_duty [CHANNELS];
  logic [BCW-1:0]      blink_cnt;
  logic                blink_phase;

  assign pwm_wrap  = (pwm_cnt == PWM_MAX);
  assign cfg_ready = rdy_q & ~pending;
  assign cfg_xfer  = cfg_valid & cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      tick_out    <= 1'b0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      tick_out <= (presc == PSW'(TICK_DIV - 1));
      presc    <= (presc == PSW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
      if (tick_out) begin
        if (blink_cnt == BCW'(BLINK_TICKS - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Pending slot lands only on the wrap edge, so a period never changes duty midway
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q     <= 1'b0;
      pending   <= 1'b0;
      pend_chan <= '0;
      pend_mode <= MODE_OFF;
      pend_duty <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= MODE_OFF;
        duty_q[i] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (cfg_xfer) begin
        pending   <= 1'b1;
        pend_chan <= cfg_chan;
        pend_mode <= mode_e'(cfg_mode);
        pend_duty <= cfg_duty;
      end else if (pending && pwm_wrap) begin
        pending <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
          if (pend_chan == 3'(i)) begin
            mode_q[i] <= pend_mode;
            duty_q[i] <= pend_duty;
          end
        end
      end
    end
  end

`ifdef LED_PWM_CTRL_BREATHE_EN
  logic [PWM_BITS-1:0]   level;
  logic                  level_up;
  logic [2*PWM_BITS-1:0] breath_prod [CHANNELS];

  // Triangle wave: bounces at both ends instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= '0;
      level_up <= 1'b1;
    end else if (tick_out) begin
      if (level_up) begin
        if (level == PWM_MAX) begin
          level_up <= 1'b0;
          level    <= level - 1'b1;
        end else begin
          level <= level + 1'b1;
        end
      end else begin
        if (level == '0) begin
          level_up <= 1'b1;
          level    <= level + 1'b1;
        end else begin
          level <= level - 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      breath_prod[i] = {{PWM_BITS{1'b0}}, duty_q[i]} * {{PWM_BITS{1'b0}}, level};
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      eff_duty[i] = '0;
      case (mode_q[i])
        MODE_STEADY:  eff_duty[i] = duty_q[i];
        MODE_BLINK:   eff_duty[i] = blink_phase ? duty_q[i] : '0;
`ifdef LED_PWM_CTRL_BREATHE_EN
        MODE_BREATHE: eff_duty[i] = PWM_BITS'(breath_prod[i] >> PWM_BITS);
`else
        MODE_BREATHE: eff_duty[i] = duty_q[i];
`endif
        default:      eff_duty[i] = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= (pwm_cnt < eff_duty[i]);
      end
    end
  end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl with PWM_BITS=4, TICK_DIV=4, BLINK_TICKS=2, CHANNELS=3.
module tb_led_pwm_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_chan = 3'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [3:0] cfg_duty = 4'd0;
  logic [2:0] pwm_out;
  logic       tick_out;

  int n_cmp = 0;
  int n_bad = 0;
  int kcyc  = 0;

  typedef struct {
    logic [2:0] ch;
    logic [1:0] md;
    logic [3:0] dt;
    int         e0;
    int         e1;
    int         e2;
  } vec_t;
  vec_t tbl [9];

  led_pwm_ctrl #(
    .CHANNELS(3), .PWM_BITS(4), .TICK_DIV(4), .BLINK_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .pwm_out(pwm_out), .tick_out(tick_out)
  );

  always #5 clk = ~clk;

  // Edges since reset release; pwm_cnt after edge k is k mod 16
  always @(posedge clk) begin
    if (rst) kcyc <= 0;
    else     kcyc <= kcyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, kcyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrap();
    do step(); while ((kcyc % 16) != 0);
  endtask

  task automatic send(input logic [2:0] ch, input logic [1:0] md, input logic [3:0] dt);
    int n = 0;
    cfg_valid = 1'b1; cfg_chan = ch; cfg_mode = md; cfg_duty = dt;
    while (!cfg_ready && n < 64) begin step(); n++; end
    if (!cfg_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: cfg_ready still 0 after %0d cycles, expected 1", n);
    end
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic measure(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      c0 += int'(pwm_out[0]); c1 += int'(pwm_out[1]); c2 += int'(pwm_out[2]);
    end
  endtask

  function automatic int bph(input int j);
    return (j >= 1) ? (((j - 1) / 8) % 2) : 0;
  endfunction

  function automatic int lvl(input int j);
    int t;
    if (j < 1) return 0;
    t = ((j - 1) / 4) % 30;
    return (t <= 15) ? t : 30 - t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, n, j, eff;

    // Cumulative channel state; starts from ch0 STEADY 5 set by the mid-period sequence
    tbl[0] = '{3'd1, 2'd1, 4'd15, 5, 15, 0};
    tbl[1] = '{3'd2, 2'd1, 4'd0,  5, 15, 0};
    tbl[2] = '{3'd2, 2'd1, 4'd1,  5, 15, 1};
    tbl[3] = '{3'd7, 2'd1, 4'd9,  5, 15, 1};
    tbl[4] = '{3'd3, 2'd1, 4'd9,  5, 15, 1};
    tbl[5] = '{3'd0, 2'd0, 4'd9,  0, 15, 1};
    tbl[6] = '{3'd0, 2'd1, 4'd8,  8, 15, 1};
    tbl[7] = '{3'd1, 2'd0, 4'd0,  8, 0,  1};
    tbl[8] = '{3'd1, 2'd2, 4'd0,  8, 0,  1};

    repeat (3) step();
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_tick_out", int'(tick_out), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    rst = 1'b0;
    step();
    chk("rel_cfg_ready", int'(cfg_ready), 1);
    chk("rel_pwm_out", int'(pwm_out), 0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("tick_out", int'(tick_out), int'((kcyc % 4) == 0));
    end

    // Mid-period config must not show before the wrap
    while ((kcyc % 16) != 5) step();
    send(3'd0, 2'd1, 4'd5);
    while ((kcyc % 16) != 0) begin
      step();
      chk("mid_period_hold", int'(pwm_out[0]), 0);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      chk("steady5_pattern", int'(pwm_out[0]), int'(((kcyc - 1) % 16) < 5));
    end

    for (int r = 0; r < 9; r++) begin
      send(tbl[r].ch, tbl[r].md, tbl[r].dt);
      wait_wrap();
      measure(c0, c1, c2);
      chk($sformatf("tbl%0d_ch0", r), c0, tbl[r].e0);
      chk($sformatf("tbl%0d_ch1", r), c1, tbl[r].e1);
      chk($sformatf("tbl%0d_ch2", r), c2, tbl[r].e2);
    end

    // Second request while the slot is busy: held off until the wrap
    send(3'd0, 2'd1, 4'd7);
    cfg_valid = 1'b1; cfg_chan = 3'd7; cfg_mode = 2'd1; cfg_duty = 4'd3;
    chk("busy_cfg_ready", int'(cfg_ready), 0);
    n = 0;
    while (!cfg_ready && n < 40) begin step(); n++; end
    chk("ready_after_wrap_phase", kcyc % 16, 0);
    step();
    cfg_valid = 1'b0;
    chk("busy_accepted", int'(cfg_ready), 0);
    wait_wrap();
    chk("chan7_ready_again", int'(cfg_ready), 1);
    measure(c0, c1, c2);
    chk("chan7_ch0", c0, 7);
    chk("chan7_ch1", c1, 0);
    chk("chan7_ch2", c2, 1);

    send(3'd1, 2'd2, 4'd15);
    wait_wrap();
    for (int i = 0; i < 32; i++) begin
      step();
      j = kcyc - 1;
      chk("blink", int'(pwm_out[1]), int'(bph(j) == 1 && (j % 16) < 15));
    end

    send(3'd2, 2'd3, 4'd15);
    wait_wrap();
    for (int i = 0; i < 128; i++) begin
      step();
      j = kcyc - 1;
`ifdef LED_PWM_CTRL_BREATHE_EN
      eff = (15 * lvl(j)) >> 4;
`else
      eff = 15;
`endif
      chk("breathe", int'(pwm_out[2]), int'((j % 16) < eff));
    end

    // Reset while a config is pending and ch0 is driving high
    while ((kcyc % 16) != 2) step();
    chk("pre_rst_active", int'(pwm_out[0]), 1);
    send(3'd0, 2'd1, 4'd15);
    rst = 1'b1;
    step();
    chk("mid_rst_pwm_out", int'(pwm_out), 0);
    chk("mid_rst_tick_out", int'(tick_out), 0);
    chk("mid_rst_cfg_ready", int'(cfg_ready), 0);
    step();
    rst = 1'b0;
    step();
    chk("rerel_cfg_ready", int'(cfg_ready), 1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rerel_tick_out", int'(tick_out), int'((kcyc % 4) == 0));
    end
    wait_wrap();
    measure(c0, c1, c2);
    chk("post_rst_ch0", c0, 0);
    chk("post_rst_ch1", c1, 0);
    chk("post_rst_ch2", c2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 3, number of independent LED channels (1..8).
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM resolution; PWM period = 2^PWM_BITS clk cycles.
REQ-003 SHALL have parameter TICK_DIV, default 48000, clk cycles per effect tick (>=2).
REQ-004 SHALL have parameter BLINK_TICKS, default 250, ticks per blink half-period (>=1).
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cfg_valid, input, 1, configuration request.
REQ-008 SHALL have port cfg_ready, output, 1, configuration slot free.
REQ-009 SHALL have port cfg_chan, input, 3, target channel index.
REQ-010 SHALL have port cfg_mode, input, 2, 0=OFF, 1=STEADY, 2=BLINK, 3=BREATHE.
REQ-011 SHALL have port cfg_duty, input, PWM_BITS, duty value.
REQ-012 SHALL have port pwm_out, output, CHANNELS, registered per-channel PWM, one bit per LED driver input.
REQ-013 SHALL have port tick_out, output, 1, one-cycle pulse per effect tick.

Function
REQ-014 SHALL: prescaler counts 0..TICK_DIV-1 and wraps; tick_out=1 for exactly the cycle after the prescaler holds TICK_DIV-1 (registered).
REQ-015 SHALL: pwm_cnt (PWM_BITS wide) increments every clk and wraps 2^PWM_BITS-1 -> 0.
REQ-016 SHALL: config handshake is transfer on cfg_valid & cfg_ready; cfg_ready = ~pending; transfer stores {chan,mode,duty} in a single pending slot and sets pending.
REQ-017 SHALL: pending slot applied to the active per-channel {mode,duty} on the edge where pwm_cnt wraps to 0, then pending cleared; no change mid-period (glitch-free).
REQ-018 SHALL: transfer on the same edge as a wrap with pending=0 is applied at the following wrap, not the current one.
REQ-019 SHALL: cfg_chan >= CHANNELS completes the handshake and is discarded at apply time with no effect.
REQ-020 SHALL: blink_phase toggles after every BLINK_TICKS ticks; shared by all channels.
REQ-021 SHALL: breath level (PWM_BITS wide) steps by 1 per tick, up to 2^PWM_BITS-1, reverses, down to 0, reverses (triangle, no wrap).
REQ-022 SHALL: effective duty = OFF 0; STEADY duty; BLINK duty if blink_phase=1 else 0; BREATHE upper PWM_BITS of duty*level (2*PWM_BITS product).
REQ-023 SHALL: pwm_out[i] registered each clk as (pwm_cnt < eff_duty[i]); latency 1 cycle from pwm_cnt; duty 0 gives constant 0, duty max gives high 2^PWM_BITS-1 of 2^PWM_BITS cycles.

Reset
REQ-024 SHALL, while rst=1: pwm_out=0, tick_out=0, cfg_ready=0, pending=0, all modes OFF, duties 0, pwm_cnt=0, prescaler=0, blink_phase=0, level=0 direction up.
REQ-025 SHALL: cfg_ready=1 on first cycle after rst deasserts; reset mid-period or with pending set discards the pending entry.

Configuration
REQ-026 SHALL: macro LED_PWM_CTRL_BREATHE_EN defined -> breath generator and multiplier built, mode 3 behaves per REQ-021/022.
REQ-027 SHALL: macro undefined -> no breath level or multiplier logic; mode 3 behaves as STEADY.

Verification (PWM_BITS=4, TICK_DIV=4, BLINK_TICKS=2, CHANNELS=3)
REQ-028 SHALL: reset 3 cycles, release -> pwm_out=000, cfg_ready=1 next cycle, tick_out every 4th cycle.
REQ-029 SHALL: cfg chan0 STEADY duty 5 mid-period -> no change until wrap, then pwm_out[0] high 5 of every 16 cycles.
REQ-030 SHALL: second cfg_valid while pending -> cfg_ready=0, request held until wrap, accepted next cycle; chan 7 -> all outputs unchanged.
REQ-031 SHALL: chan1 BLINK duty 15 -> pwm_out[1] pattern 15/16 high for 8 cycles (2 ticks), fully low 8 cycles, repeating.
REQ-032 SHALL: with LED_PWM_CTRL_BREATHE_EN, chan2 BREATHE duty 15 -> level 0..15..0 over 30 ticks, high count per period = (15*level)>>4; without macro equals STEADY 15.
REQ-033 SHALL: assert rst while pending set and outputs active -> next cycle all REQ-024 values, pending entry never applied.
